// File: rtl/nn_infer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nn_infer_seq_pkg
// Purpose  : Shared defaults and state encoding for the inference sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package nn_infer_seq_pkg;

    localparam int c_N_HID_DEF  = 200;
    localparam int c_IDX_W_DEF  = 8;
    localparam int c_L1_LAT_DEF = 12;
    localparam int c_L2_LAT_DEF = 2;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_L1_INIT  = 3'd1;
    localparam state_t c_ST_L1_RUN   = 3'd2;
    localparam state_t c_ST_L1_DRAIN = 3'd3;
    localparam state_t c_ST_L2_INIT  = 3'd4;
    localparam state_t c_ST_L2_RUN   = 3'd5;
    localparam state_t c_ST_L2_DRAIN = 3'd6;
    localparam state_t c_ST_DONE     = 3'd7;

    function automatic logic state_is_busy(input state_t s);
        return (s != c_ST_IDLE);
    endfunction

endpackage : nn_infer_seq_pkg
`default_nettype wire

// File: rtl/nn_infer_seq_idx_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : idx_delay_line
// Purpose  : Valid + index shift register with synchronous active-low flush.
// Revision : 1.0 - initial release
// ============================================================================
module idx_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         i_flush_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_idx,
    output logic         o_valid,
    output logic [W-1:0] o_idx,
    output logic         o_empty_next
);

    logic         r_vld [DEPTH];
    logic [W-1:0] r_idx [DEPTH];
    logic         w_upper_vld;

    always_ff @(posedge clk) begin
        if (!i_flush_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_vld[k] <= 1'b0;
                r_idx[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_idx[0] <= i_idx;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_idx[k] <= r_idx[k-1];
            end
        end
    end

    // Only the final stage may still be occupied: the line is empty after the next edge.
    if (DEPTH > 1) begin : g_multi
        always_comb begin
            w_upper_vld = 1'b0;
            for (int k = 0; k < DEPTH - 1; k++) begin
                w_upper_vld = w_upper_vld | r_vld[k];
            end
        end
    end else begin : g_single
        assign w_upper_vld = 1'b0;
    end

    assign o_valid      = r_vld[DEPTH-1];
    assign o_idx        = r_idx[DEPTH-1];
    assign o_empty_next = ~w_upper_vld;

endmodule : idx_delay_line
`default_nettype wire

// File: rtl/nn_infer_seq.sv
`default_nettype none
// ============================================================================
// Module   : nn_infer_seq
// Purpose  : Sequences one forward pass of the 784-200-10 MNIST network.
// Revision : 1.0 - initial release
// ============================================================================
module nn_infer_seq
    import nn_infer_seq_pkg::*;
#(
    parameter int N_HID  = c_N_HID_DEF,
    parameter int IDX_W  = c_IDX_W_DEF,
    parameter int L1_LAT = c_L1_LAT_DEF,
    parameter int L2_LAT = c_L2_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load_active,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    output logic             sram_rewind,
    output logic             l1_shift,
    output logic [IDX_W-1:0] l1_idx,
    output logic             hid_we,
    output logic [IDX_W-1:0] hid_wr_idx,
    output logic             l2_shift,
    output logic [IDX_W-1:0] hid_rd_idx,
    output logic             bias_sel,
    output logic             acc_clr,
    output logic             acc_en
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_l1_cnt;
    logic [IDX_W-1:0]   r_l2_cnt;
    logic               w_l1_last;
    logic               w_l2_last;

    logic               w_busy;
    logic               w_sram_rewind;
    logic               w_l1_shift;
    logic               w_l2_shift;
    logic               w_acc_clr;
    logic               w_done;
    logic               w_bias_flag;

    logic               w_dl1_vld;
    logic [IDX_W-1:0]   w_dl1_idx;
    logic               w_dl1_empty_nxt;
    logic               w_dl2_vld;
    logic               w_dl2_bias;
    logic               w_dl2_empty_nxt;

    assign w_l1_last = (r_l1_cnt == IDX_W'(N_HID - 1));
    assign w_l2_last = (r_l2_cnt == IDX_W'(N_HID));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (start && !load_active) w_state_nxt = c_ST_L1_INIT;
            c_ST_L1_INIT:  w_state_nxt = c_ST_L1_RUN;
            c_ST_L1_RUN:   if (w_l1_last) w_state_nxt = c_ST_L1_DRAIN;
            c_ST_L1_DRAIN: if (w_dl1_empty_nxt) w_state_nxt = c_ST_L2_INIT;
            c_ST_L2_INIT:  w_state_nxt = c_ST_L2_RUN;
            c_ST_L2_RUN:   if (w_l2_last) w_state_nxt = c_ST_L2_DRAIN;
            c_ST_L2_DRAIN: if (w_dl2_empty_nxt) w_state_nxt = c_ST_DONE;
            c_ST_DONE:     w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy        = state_is_busy(r_state);
        w_sram_rewind = (r_state == c_ST_L1_INIT);
        w_l1_shift    = (r_state == c_ST_L1_RUN);
        w_acc_clr     = (r_state == c_ST_L2_INIT);
        w_l2_shift    = (r_state == c_ST_L2_RUN);
        w_done        = (r_state == c_ST_DONE);
        w_bias_flag   = w_l2_shift && w_l2_last;
    end

    // Counters hold their final value instead of wrapping once the run ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_l1_cnt <= '0;
            r_l2_cnt <= '0;
        end else begin
            if (r_state == c_ST_L1_INIT) begin
                r_l1_cnt <= '0;
            end else if (w_l1_shift && !w_l1_last) begin
                r_l1_cnt <= r_l1_cnt + 1'b1;
            end
            if (r_state == c_ST_L2_INIT) begin
                r_l2_cnt <= '0;
            end else if (w_l2_shift && !w_l2_last) begin
                r_l2_cnt <= r_l2_cnt + 1'b1;
            end
        end
    end

    idx_delay_line #(
        .DEPTH (L1_LAT),
        .W     (IDX_W)
    ) u_l1_dly (
        .clk          (clk),
        .i_flush_n    (reset),
        .i_valid      (w_l1_shift),
        .i_idx        (r_l1_cnt),
        .o_valid      (w_dl1_vld),
        .o_idx        (w_dl1_idx),
        .o_empty_next (w_dl1_empty_nxt)
    );

    idx_delay_line #(
        .DEPTH (L2_LAT),
        .W     (1)
    ) u_l2_dly (
        .clk          (clk),
        .i_flush_n    (reset),
        .i_valid      (w_l2_shift),
        .i_idx        (w_bias_flag),
        .o_valid      (w_dl2_vld),
        .o_idx        (w_dl2_bias),
        .o_empty_next (w_dl2_empty_nxt)
    );

    // Every output is a flop; the delay-line outputs take their final stage here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            sram_rewind <= 1'b0;
            l1_shift    <= 1'b0;
            l1_idx      <= '0;
            hid_we      <= 1'b0;
            hid_wr_idx  <= '0;
            l2_shift    <= 1'b0;
            hid_rd_idx  <= '0;
            bias_sel    <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
        end else begin
            busy        <= w_busy;
            done        <= w_done;
            sram_rewind <= w_sram_rewind;
            l1_shift    <= w_l1_shift;
            l1_idx      <= r_l1_cnt;
            hid_we      <= w_dl1_vld;
            hid_wr_idx  <= w_dl1_idx;
            l2_shift    <= w_l2_shift;
            hid_rd_idx  <= r_l2_cnt;
            bias_sel    <= w_dl2_vld & w_dl2_bias;
            acc_clr     <= w_acc_clr;
            acc_en      <= w_dl2_vld;
            if (w_sram_rewind) begin
                out_valid <= 1'b0;
            end else if (w_done) begin
                out_valid <= 1'b1;
            end
        end
    end

endmodule : nn_infer_seq
`default_nettype wire

// File: tb/tb_nn_infer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_infer_seq
// Purpose  : Self-checking bench: default sequencer plus a small N_HID=3 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_infer_seq;

    localparam int NA = 200, L1A = 12, L2A = 2;
    localparam int NB = 3,   L1B = 1,  L2B = 1;

    typedef struct packed {
        logic       busy, rew, l1s, hwe, clr, l2s, acc, bias, done, ov;
        logic [7:0] l1i, wri, rdi;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b, load_active;
    logic busy_a, done_a, ov_a, rew_a, l1s_a, hwe_a, l2s_a, bias_a, clr_a, acc_a;
    logic busy_b, done_b, ov_b, rew_b, l1s_b, hwe_b, l2s_b, bias_b, clr_b, acc_b;
    logic [7:0] l1i_a, wri_a, rdi_a, l1i_b, wri_b, rdi_b;

    int n_vec = 0;
    int n_err = 0;
    logic mv [2];

    nn_infer_seq u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .load_active(load_active),
        .busy(busy_a), .done(done_a), .out_valid(ov_a), .sram_rewind(rew_a),
        .l1_shift(l1s_a), .l1_idx(l1i_a), .hid_we(hwe_a), .hid_wr_idx(wri_a),
        .l2_shift(l2s_a), .hid_rd_idx(rdi_a), .bias_sel(bias_a),
        .acc_clr(clr_a), .acc_en(acc_a)
    );

    nn_infer_seq #(.N_HID(NB), .IDX_W(8), .L1_LAT(L1B), .L2_LAT(L2B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .load_active(load_active),
        .busy(busy_b), .done(done_b), .out_valid(ov_b), .sram_rewind(rew_b),
        .l1_shift(l1s_b), .l1_idx(l1i_b), .hid_we(hwe_b), .hid_wr_idx(wri_b),
        .l2_shift(l2s_b), .hid_rd_idx(rdi_b), .bias_sel(bias_b),
        .acc_clr(clr_b), .acc_en(acc_b)
    );

    function automatic obs_t get_obs(input int sel, input bit raw);
        obs_t o;
        if (sel == 0)
            o = '{busy_a, rew_a, l1s_a, hwe_a, clr_a, l2s_a, acc_a, bias_a, done_a, ov_a,
                  l1i_a, wri_a, rdi_a};
        else
            o = '{busy_b, rew_b, l1s_b, hwe_b, clr_b, l2s_b, acc_b, bias_b, done_b, ov_b,
                  l1i_b, wri_b, rdi_b};
        if (!raw) begin
            if (!o.l1s) o.l1i = '0;
            if (!o.hwe) o.wri = '0;
            if (!o.l2s) o.rdi = '0;
        end
        return o;
    endfunction

    // Expected outputs at cycle c of a pass, straight from the pass timeline.
    function automatic obs_t exp_obs(input int c, input int n, input int l1, input int l2,
                                     input logic pv);
        obs_t e;
        int ca, d;
        e  = '0;
        ca = n + 2 + l1;
        d  = ca + n + 2 + l2;
        e.busy = (c >= 1 && c <= d);
        e.rew  = (c == 1);
        e.l1s  = (c >= 2 && c <= n + 1);
        e.hwe  = (c >= 2 + l1 && c <= n + 1 + l1);
        e.clr  = (c == ca);
        e.l2s  = (c >= ca + 1 && c <= ca + n + 1);
        e.acc  = (c >= ca + 1 + l2 && c <= ca + n + 1 + l2);
        e.bias = (c == ca + n + 1 + l2);
        e.done = (c == d);
        e.ov   = (c == 0) ? pv : (c == d);
        if (e.l1s) e.l1i = 8'(c - 2);
        if (e.hwe) e.wri = 8'(c - 2 - l1);
        if (e.l2s) e.rdi = 8'(c - ca - 1);
        return e;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    // Caller has start high and load_active low: the next edge is cycle 0.
    task automatic run_pass(input int sel, input bit hold);
        int n, l1, l2, d, we_cnt, acc_cnt;
        obs_t act, exp;
        n  = (sel == 0) ? NA : NB;
        l1 = (sel == 0) ? L1A : L1B;
        l2 = (sel == 0) ? L2A : L2B;
        d  = (n + 2 + l1) + n + 2 + l2;
        we_cnt  = 0;
        acc_cnt = 0;
        for (int c = 0; c <= d; c++) begin
            @(posedge clk); #1;
            act = get_obs(sel, 1'b0);
            exp = exp_obs(c, n, l1, l2, mv[sel]);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL pass dut%0d cyc %0d: got %h want %h", sel, c, act, exp);
            end
            if (act.hwe) we_cnt++;
            if (act.acc) acc_cnt++;
            if (c < d) begin
                set_start(sel, hold ? 1'b1 : logic'($urandom_range(0, 1)));
                load_active = ($urandom_range(0, 3) == 0);
            end else begin
                set_start(sel, hold);
                load_active = 1'b0;
            end
        end
        mv[sel] = 1'b1;
        n_vec++;
        if (we_cnt !== n || acc_cnt !== n + 1) begin
            n_err++;
            $display("FAIL strobe_count dut%0d: hid_we %0d acc_en %0d, want %0d and %0d",
                     sel, we_cnt, acc_cnt, n, n + 1);
        end
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        for (int s = 0; s < 2; s++) begin
            a = get_obs(s, 1'b1);
            n_vec++;
            if (a !== '0) begin
                n_err++;
                $display("FAIL %s dut%0d: got %h want 0", name, s, a);
            end
        end
    endtask

    task automatic test_reset();
        int hit, k;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; load_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b1;
        start_a = 1'b1;
        hit = -1;
        for (int c = 0; c < 100 && hit < 0; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (l1s_a && l1i_a == 8'd57) hit = c;
        end
        n_vec++;
        if (hit != 59) begin
            n_err++;
            $display("FAIL l1_idx57_cycle: got %0d want 59", hit);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check_zero("reset_mid_l1");
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("idle_after_reset");
        mv[0] = 1'b0; mv[1] = 1'b0;
        start_a = 1'b1;
        run_pass(0, 1'b0);
        // Second abort at a random point of a pass.
        k = $urandom_range(1, 417);
        start_a = 1'b1;
        repeat (k) begin
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check_zero("reset_random");
        reset = 1'b1;
        mv[0] = 1'b0;
    endtask

    task automatic test_load_block();
        int k;
        k = $urandom_range(3, 8);
        load_active = 1'b1;
        start_a = 1'b1;
        repeat (k) begin
            @(posedge clk); #1;
            n_vec++;
            if (busy_a !== 1'b0 || rew_a !== 1'b0 || ov_a !== mv[0]) begin
                n_err++;
                $display("FAIL load_block: busy %b rewind %b out_valid %b, want 0 0 %b",
                         busy_a, rew_a, ov_a, mv[0]);
            end
        end
        load_active = 1'b0;
        run_pass(0, 1'b0);
    endtask

    task automatic test_nominal();
        start_a = 1'b1;
        run_pass(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_a = 1'b1;
        run_pass(0, 1'b1);
        run_pass(0, 1'b0);
    endtask

    task automatic test_param_sweep();
        start_b = 1'b1;
        run_pass(1, 1'b0);
        start_b = 1'b1;
        run_pass(1, 1'b1);
        run_pass(1, 1'b0);
    endtask

    initial begin
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        test_reset();
        test_load_block();
        test_nominal();
        test_back_to_back();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_nn_infer_seq
`default_nettype wire
